// File: rtl/nand_stim_chk.sv
// Stimulus/response checker for a 2-input NAND cell: drives in1/in2 square waves,
// samples out1 after a settle delay and accumulates mismatch statistics per run.
module nand_stim_chk #(
  parameter int HALF1      = 4,
  parameter int HALF2      = 8,
  parameter int SETTLE     = 2,
  parameter int NUM_SWEEPS = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             out1,
  output logic             in1,
  output logic             in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [1:0]       first_err
);

  localparam int RUN_LEN = 2 * HALF2 * NUM_SWEEPS;
  localparam int TW      = $clog2(RUN_LEN + 1);
  localparam int H1W     = $clog2(HALF1);
  localparam int H2W     = $clog2(HALF2);
  localparam int SW      = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  localparam logic [TW-1:0]  RUN_END  = TW'(RUN_LEN);
  localparam logic [TW-1:0]  RUN_LAST = TW'(RUN_LEN - 1);
  localparam logic [H1W-1:0] PH1_TOP  = H1W'(HALF1 - 1);
  localparam logic [H2W-1:0] PH2_TOP  = H2W'(HALF2 - 1);
  localparam logic [SW-1:0]  SETTLE_V = SW'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [TW-1:0]  t;
  logic [H1W-1:0] ph1;
  logic [H2W-1:0] ph2;
  logic [SW-1:0]  settle;
  logic           pending;

  logic expected;
  logic mismatch;
  logic check_now;
  logic tog1;
  logic tog2;

  // Phase counters track t mod HALFn so toggles need no divider; no toggle may
  // land on or after RUN_LEN.
  always_comb begin
    expected  = ~(in1 & in2);
    mismatch  = (out1 === expected) ? 1'b0 : 1'b1;
    check_now = pending && (settle == '0);
    tog1      = (ph1 == PH1_TOP) && (t < RUN_LAST);
    tog2      = (ph2 == PH2_TOP) && (t < RUN_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      t         <= '0;
      ph1       <= '0;
      ph2       <= '0;
      settle    <= '0;
      pending   <= 1'b0;
      in1       <= 1'b0;
      in2       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      first_err <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            t         <= '0;
            ph1       <= '0;
            ph2       <= '0;
            settle    <= SETTLE_V;
            pending   <= 1'b1;
            in1       <= 1'b0;
            in2       <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            chk_cnt   <= '0;
            first_err <= 2'b00;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            t       <= '0;
            ph1     <= '0;
            ph2     <= '0;
            settle  <= '0;
            pending <= 1'b0;
            in1     <= 1'b0;
            in2     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
          end else if ((t == RUN_END) && !pending) begin
            state <= DONE;
            t     <= '0;
            ph1   <= '0;
            ph2   <= '0;
            in1   <= 1'b0;
            in2   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end else begin
            if (t < RUN_END) begin
              t   <= t + TW'(1);
              ph1 <= (ph1 == PH1_TOP) ? '0 : ph1 + H1W'(1);
              ph2 <= (ph2 == PH2_TOP) ? '0 : ph2 + H2W'(1);
            end
            if (settle != '0)
              settle <= settle - SW'(1);
            if (check_now) begin
              chk_cnt <= chk_cnt + CNT_W'(1);
              pending <= 1'b0;
              if (mismatch) begin
                if (err_cnt != '1)
                  err_cnt <= err_cnt + CNT_W'(1);
                if (err_cnt == '0)
                  first_err <= {in2, in1};
              end
            end
            if (tog1)
              in1 <= ~in1;
            if (tog2)
              in2 <= ~in2;
            // A new stimulus edge always re-arms the check, even over a completing one.
            if (tog1 || tog2) begin
              settle  <= SETTLE_V;
              pending <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
